// File: rtl/mem_access.sv
// mem_access: MEM stage issuing at most one data-memory transaction per instruction,
// extracting load data and flagging misaligned accesses.
module mem_access #(
  parameter bit STRICT_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_valid,
  input  logic [4:0]  mem_control,
  input  logic [31:0] exe_result,
  input  logic [31:0] store_data,
  input  logic        ls_bytes_L,
  input  logic        ls_bytes_R,
  input  logic [3:0]  rf_wbytes,
  input  logic        flush,
  input  logic        WB_allowin,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        MEM_over,
  output logic [31:0] load_result,
  output logic [3:0]  MEM_wbytes,
  output logic        addr_err_load,
  output logic        addr_err_store
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic ld, st, is_word, is_half, l_unsign, lr, misalign, addr_err, start, capture;
  logic cancel_q, cancel_d;
  logic [1:0] off, off_q;
  logic [31:0] addr_q, wdata_q, wdata_c, load_result_q, ext;
  logic [3:0] wstrb_q, wstrb_c, wbytes_q;
  logic wr_q, word_q, half_q, unsign_q, l_q, r_q;
  logic [2:0] cnt;
  logic [5:0] amt;
  logic [7:0] b;
  logic [15:0] h;
  assign {ld, st, is_word, is_half, l_unsign} = mem_control;
  assign off = exe_result[1:0];
  assign lr = ls_bytes_L | ls_bytes_R;
  assign misalign = STRICT_ALIGN && !lr && (is_word ? off != 2'b00 : is_half && off[0]);
  assign addr_err = (ld | st) & misalign;
  assign start = MEM_valid & (ld | st) & ~addr_err & ~flush;
  assign capture = state_q == IDLE && start;
  assign wstrb_c = !st ? 4'b0000 : is_word ? 4'b1111 : is_half ? 4'b0011 << off : 4'b0001 << off;
  assign wdata_c = is_word ? store_data : is_half ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
  // LWL and LWR both shift by 8*(4-popcount), left and right respectively
  assign cnt = 3'($countones(wbytes_q));
  assign amt = {3'd4 - cnt, 3'b000};
  assign b = 8'(data_rdata >> {off_q, 3'b000});
  assign h = off_q[1] ? data_rdata[31:16] : data_rdata[15:0];
  assign ext = l_q ? data_rdata << amt : r_q ? data_rdata >> amt : word_q ? data_rdata :
               half_q ? {{16{~unsign_q & h[15]}}, h} : {{24{~unsign_q & b[7]}}, b};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cancel_q <= 1'b0;
      load_result_q <= '0;
    end else begin
      state_q <= state_d;
      cancel_q <= cancel_d;
      if (state_q == WAIT && data_data_ok) load_result_q <= ext;
    end
  end
  // request and extraction context is frozen at issue so it survives input changes
  always_ff @(posedge clk) begin
    if (capture)
      {addr_q, wr_q, wstrb_q, wdata_q, word_q, half_q, unsign_q, l_q, r_q, off_q, wbytes_q} <=
        {exe_result, st, wstrb_c, wdata_c, is_word, is_half, l_unsign, ls_bytes_L, ls_bytes_R, off, rf_wbytes};
  end
  always_comb begin
    state_d = state_q;
    cancel_d = cancel_q;
    case (state_q)
      IDLE: state_d = start ? (data_addr_ok ? WAIT : REQ) : IDLE;
      REQ: begin
        state_d = data_addr_ok ? WAIT : flush ? IDLE : REQ;
        cancel_d = flush & data_addr_ok;
      end
      WAIT: begin
        state_d = data_data_ok ? (cancel_q | flush ? IDLE : DONE) : WAIT;
        cancel_d = ~data_data_ok & (cancel_q | flush);
      end
      DONE: state_d = WB_allowin ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    data_req = capture || state_q == REQ;
    data_addr = state_q == REQ ? addr_q : exe_result;
    data_wr = state_q == REQ ? wr_q : st;
    data_wstrb = state_q == REQ ? wstrb_q : wstrb_c;
    data_wdata = state_q == REQ ? wdata_q : wdata_c;
    MEM_over = state_q == DONE || (state_q == IDLE && MEM_valid && (!(ld || st) || addr_err));
    addr_err_load = state_q == IDLE && MEM_valid && ld && misalign;
    addr_err_store = state_q == IDLE && MEM_valid && st && misalign;
    MEM_wbytes = state_q == DONE ? (l_q | r_q ? wbytes_q : 4'hf) : (lr ? rf_wbytes : 4'hf);
    load_result = load_result_q;
  end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the EXE->MEM payload fields and issues at most one data-memory transaction per instruction over a req/addr_ok/data_ok handshake.
- Extracts and sign/zero-extends load data, including LWL/LWR shifted partial words, and raises alignment exceptions.
- Holds MEM_over until the writeback stage accepts the result.

Parameters:
STRICT_ALIGN, 1, 1 = LW/LH/LHU/SW/SH misalignment raises address error and suppresses the request; 0 = no check (request issued as-is).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
MEM_valid  in  1  instruction present in MEM
mem_control  in  5  {load, store, ls_word, ls_dbyte, l_unsign}
exe_result  in  32  effective address (LWL/LWR already word-aligned by EXE)
store_data  in  32  store source register value
ls_bytes_L  in  1  LWL/SWL
ls_bytes_R  in  1  LWR/SWR
rf_wbytes  in  4  register byte-write mask computed in EXE
flush  in  1  exception/eret cancel of current MEM instruction
WB_allowin  in  1  writeback accepts this cycle
data_req  out  1  memory request
data_wr  out  1  1 = write
data_wstrb  out  4  byte strobes (0000 on reads)
data_addr  out  32  request address
data_wdata  out  32  write data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  read data valid / write complete
data_rdata  in  32  read data
MEM_over  out  1  stage result ready
load_result  out  32  extracted load value
MEM_wbytes  out  4  byte mask forwarded to WB
addr_err_load  out  1  load alignment exception
addr_err_store  out  1  store alignment exception

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset enters IDLE from any state, including mid-transaction.
- Reset values: data_req=0, MEM_over=0, load_result=0, error flags=0, cancel flag=0.
- start = MEM_valid & (load|store) & ~addr_err & ~flush.
- data_req = (IDLE & start) | REQ.
- data_addr/data_wr/data_wstrb/data_wdata are held stable while data_req=1 without addr_ok.
- IDLE transitions:
  - start & addr_ok -> WAIT.
  - start & ~addr_ok -> REQ.
  - Non-memory instruction: MEM_over = MEM_valid combinationally; stay IDLE.
- REQ transitions:
  - addr_ok -> WAIT.
  - flush & ~addr_ok -> IDLE; no transaction.
- WAIT transitions:
  - data_ok -> latch extracted data; -> DONE, or -> IDLE if cancel flag set.
  - flush in WAIT, or coincident with addr_ok, sets the cancel flag. The outstanding data_ok is always absorbed; never abandoned.
- DONE: MEM_over=1; load_result held. WB_allowin -> IDLE.
- data_ok outside WAIT is ignored.
- Best-case load/store: addr_ok at cycle 0, data_ok at 1, MEM_over at 2.
- Address error (STRICT_ALIGN=1, excluding ls_bytes_L|R):
  - Conditions: word with addr[1:0]!=0; half with addr[0]=1.
  - Flag is asserted combinationally with MEM_over=MEM_valid. No request.
- Store strobes, off = addr[1:0]:
  - byte: wstrb = 0001<<off, wdata = {4{b}}.
  - half: wstrb = 0011<<off, wdata = {2{h}}.
  - word: wstrb = 1111, wdata unchanged.
- Load extraction:
  - LB/LBU: byte[off], sign-extended unless l_unsign.
  - LH/LHU: half[off[1]], sign-extended unless l_unsign.
  - LW: rdata.
  - LWL: n = popcount(rf_wbytes)-1; result = rdata << 8*(3-n).
  - LWR: n = 4-popcount(rf_wbytes); result = rdata >> 8*n.
- MEM_wbytes = rf_wbytes for LWL/LWR, else 1111.

Test Plan:
- LB addr 0x00001003, rdata 0x80FF1234, addr_ok cycle 0, data_ok cycle 2 -> data_wr=0, wstrb=0000; MEM_over cycle 3; load_result 0xFFFFFF80. LBU same stimulus -> 0x00000080.
- SH addr 0x00002002, store_data 0x0000ABCD, addr_ok delayed to cycle 3 -> req held with stable addr 0x00002002, wstrb=1100, wdata=0xABCDABCD, wr=1.
- LW addr 0x00000006 -> addr_err_load=1 and MEM_over=1 in same cycle; data_req never asserted. SW same address -> addr_err_store=1.
- LWL rf_wbytes=1100, rdata 0x11223344 -> load_result 0x33440000, MEM_wbytes 1100. LWR rf_wbytes=0011 -> 0x00001122, MEM_wbytes 0011.
- Load: addr_ok cycle 0, flush cycle 1, data_ok cycle 3 -> MEM_over never asserted; IDLE at cycle 4; next load asserts data_req at cycle 4.
- WB_allowin=0 for 4 cycles in DONE -> MEM_over and load_result stay constant; no new request. rst in WAIT -> next cycle IDLE, data_req=0, MEM_over=0.
